// File: rtl/regfile_pkg.sv
// Shared register-file types for the write-port arbiter: address widths,
// the queued LLU entry layout and the stall FSM states.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int NUM_REGS = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } llu_entry_t;

    typedef enum logic {
        IDLE,
        STALL
    } arbState_t;
endpackage

// File: rtl/llu_result_fifo.sv
// Small circular queue of LLU results with a per-entry WAW kill port and
// registered pending-write mask built from the live entries.
module llu_result_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] pushDest,
    input  logic [DATA_W-1:0]     pushData,
    input  logic                  pop,
    input  logic                  killEn,
    input  logic [REG_ADDR_W-1:0] killDest,
    output logic                  full,
    output logic                  empty,
    output logic                  headLive,
    output logic [REG_ADDR_W-1:0] headDest,
    output logic [DATA_W-1:0]     headData,
    output logic [NUM_REGS-1:0]   pendingMask
);
    localparam int PTR_W = $clog2(DEPTH);

    llu_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]    rdPtr;
    logic [PTR_W-1:0]    wrPtr;
    logic [PTR_W:0]      count;
    logic [DEPTH-1:0]    nextLive;
    logic [NUM_REGS-1:0] nextMask;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign headLive = !empty && mem[rdPtr].live;
    assign headDest = mem[rdPtr].dest;
    assign headData = mem[rdPtr].data;

    // Live bits after this edge: kill first, then a popped slot dies and a pushed slot is born.
    always_comb begin
        nextLive = '0;
        nextMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            nextLive[i] = mem[i].live && !(killEn && (mem[i].dest == killDest));
            if (pop && (rdPtr == PTR_W'(i)))
                nextLive[i] = 1'b0;
            if (push && (wrPtr == PTR_W'(i)))
                nextLive[i] = 1'b1;
            if (nextLive[i])
                nextMask[(push && (wrPtr == PTR_W'(i))) ? pushDest : mem[i].dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            pendingMask <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                mem[i].live <= nextLive[i];
            if (push) begin
                mem[wrPtr].dest <= pushDest;
                mem[wrPtr].data <= pushData;
                wrPtr           <= wrPtr + PTR_W'(1);
            end
            if (pop)
                rdPtr <= rdPtr + PTR_W'(1);
            if (push && !pop)
                count <= count + (PTR_W+1)'(1);
            else if (pop && !push)
                count <= count - (PTR_W+1)'(1);
            pendingMask <= nextMask;
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between WB (zero latency, priority) and
// queued LLU results; raises a stall when the queue head starves.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int N            = DATA_W,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [N-1:0]          wb_data,
    input  logic                  llu_valid,
    output logic                  llu_ready,
    input  logic [REG_ADDR_W-1:0] llu_reg,
    input  logic [N-1:0]          llu_data,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [N-1:0]          WriteData,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic                  stall_req
);
    localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;

    arbState_t             state;
    arbState_t             stateNext;
    logic [CNT_W-1:0]      starveCnt;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  headLive;
    logic [REG_ADDR_W-1:0] headDest;
    logic [N-1:0]          headData;
    logic                  wbActive;
    logic                  drainHead;
    logic                  popHead;
    logic                  headWaiting;
    logic                  lluFire;
    logic                  pushEn;

    // Outputs are gated by reset so nothing reaches the register file while it is held.
    assign stall_req   = (state == STALL);
    assign llu_ready   = reset && !fifoFull;
    assign wbActive    = reset && !stall_req && wb_regwrite && (wb_reg != REG_ZERO);
    assign drainHead   = headLive && (stall_req || !wbActive);
    assign popHead     = !fifoEmpty && (!headLive || drainHead);
    assign headWaiting = headLive && !drainHead;
    assign lluFire     = llu_valid && llu_ready;
    assign pushEn      = lluFire && (llu_reg != REG_ZERO) && !(wbActive && (wb_reg == llu_reg));

    assign RegWrite      = wbActive || drainHead;
    assign WriteRegister = wbActive ? wb_reg  : headDest;
    assign WriteData     = wbActive ? wb_data : headData;

    llu_result_fifo #(
        .DEPTH(DEPTH)
    ) resultFifo (
        .clk        (clk),
        .reset      (reset),
        .push       (pushEn),
        .pushDest   (llu_reg),
        .pushData   (llu_data),
        .pop        (popHead),
        .killEn     (wbActive),
        .killDest   (wb_reg),
        .full       (fifoFull),
        .empty      (fifoEmpty),
        .headLive   (headLive),
        .headDest   (headDest),
        .headData   (headData),
        .pendingMask(pending_mask)
    );

    // Counts cycles a live head is passed over; any pop or loss of a live head restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starveCnt <= '0;
        else if (popHead || !headLive)
            starveCnt <= '0;
        else
            starveCnt <= starveCnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (headWaiting && (starveCnt == CNT_W'(STARVE_LIMIT - 1))) stateNext = STALL;
            STALL:   if (drainHead) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: stimulus pushes expected register-file writes into a queue,
// a negedge monitor pops and compares every write the arbiter issues.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_regwrite = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic        llu_valid = 1'b0;
    logic        llu_ready;
    logic [4:0]  llu_reg = '0;
    logic [31:0] llu_data = '0;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] pending_mask;
    logic        stall_req;

    int passCount = 0;
    int checkCount = 0;
    logic [36:0] expQ [$];

    regfile_write_arbiter #(
        .N(32), .DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_regwrite  (wb_regwrite),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .llu_valid    (llu_valid),
        .llu_ready    (llu_ready),
        .llu_reg      (llu_reg),
        .llu_data     (llu_data),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .pending_mask (pending_mask),
        .stall_req    (stall_req)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic wr, input logic [4:0] wreg, input logic [31:0] wdata,
                                 input logic lv, input logic [4:0] lreg, input logic [31:0] ldata);
        wb_regwrite = wr;
        wb_reg      = wreg;
        wb_data     = wdata;
        llu_valid   = lv;
        llu_reg     = lreg;
        llu_data    = ldata;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic expectWrite(input logic [4:0] r, input logic [31:0] d);
        expQ.push_back({r, d});
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        logic [36:0] e;
        if (RegWrite !== 1'b0) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", {26'd0, RegWrite, WriteRegister, WriteData}, 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("write", {27'd0, WriteRegister, WriteData}, {27'd0, e});
            end
        end
    end

    initial begin
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 5'd5, 32'h77, 1'b1, 5'd6, 32'h66);
        checkOutput("resetRegWrite", 64'(RegWrite), 64'd0);
        checkOutput("resetLluReady", 64'(llu_ready), 64'd0);
        checkOutput("resetPending", 64'(pending_mask), 64'd0);
        checkOutput("resetStall", 64'(stall_req), 64'd0);
        nextCycle();
        reset = 1'b1;
        idle();
        checkOutput("releaseReady", 64'(llu_ready), 64'd1);

        // Reset mid-queue: three LLU entries queued behind a busy WB.
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            applyStimulus(1'b1, 5'd11, 32'(k), 1'b1, 5'(5 + k), 32'(32'h50 + k));
            expectWrite(5'd11, 32'(k));
        end
        nextCycle();
        checkOutput("queuedPending", 64'(pending_mask), 64'h0000_00E0);
        reset = 1'b0;
        applyStimulus(1'b1, 5'd12, 32'h99, 1'b0, 5'd0, 32'd0);
        checkOutput("midResetPending", 64'(pending_mask), 64'd0);
        checkOutput("midResetRegWrite", 64'(RegWrite), 64'd0);
        checkOutput("midResetReady", 64'(llu_ready), 64'd0);
        nextCycle();
        reset = 1'b1;
        idle();
        checkOutput("afterResetReady", 64'(llu_ready), 64'd1);
        checkOutput("afterResetPending", 64'(pending_mask), 64'd0);
        nextCycle();
        idle();

        // Idle drain of $t0.
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h1234);
        checkOutput("drainReady", 64'(llu_ready), 64'd1);
        nextCycle();
        idle();
        checkOutput("drainPendingSet", 64'(pending_mask), 64'h0000_0100);
        expectWrite(5'd8, 32'h1234);
        nextCycle();
        checkOutput("drainPendingClr", 64'(pending_mask), 64'd0);

        // WAW kill of a queued $s0.
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 32'hAAAA);
        nextCycle();
        applyStimulus(1'b1, 5'd16, 32'h5555, 1'b0, 5'd0, 32'd0);
        checkOutput("wawPendingSet", 64'(pending_mask), 64'h0001_0000);
        expectWrite(5'd16, 32'h5555);
        nextCycle();
        idle();
        checkOutput("wawPendingKilled", 64'(pending_mask), 64'd0);
        nextCycle();

        // Same-cycle WB and LLU to $t1: the LLU result is dropped.
        applyStimulus(1'b1, 5'd9, 32'd1, 1'b1, 5'd9, 32'd2);
        expectWrite(5'd9, 32'd1);
        nextCycle();
        idle();
        checkOutput("sameCycleKillPending", 64'(pending_mask), 64'd0);

        // Fill the FIFO behind a busy WB, then drain it; $zero transfer afterwards.
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            applyStimulus(1'b1, 5'd11, 32'(32'h200 + k), 1'b1, 5'(20 + k), 32'(32'h100 + k));
            checkOutput("fillReady", 64'(llu_ready), 64'd1);
            expectWrite(5'd11, 32'(32'h200 + k));
        end
        nextCycle();
        applyStimulus(1'b1, 5'd11, 32'h204, 1'b1, 5'd24, 32'h104);
        checkOutput("fullReady", 64'(llu_ready), 64'd0);
        checkOutput("fullPending", 64'(pending_mask), 64'h00F0_0000);
        expectWrite(5'd11, 32'h204);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd24, 32'h104);
        checkOutput("fullPopReady", 64'(llu_ready), 64'd0);
        expectWrite(5'd20, 32'h100);
        nextCycle();
        idle();
        checkOutput("drainingPending", 64'(pending_mask), 64'h00E0_0000);
        expectWrite(5'd21, 32'h101);
        nextCycle();
        expectWrite(5'd22, 32'h102);
        nextCycle();
        expectWrite(5'd23, 32'h103);
        nextCycle();
        checkOutput("drainedPending", 64'(pending_mask), 64'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        checkOutput("zeroReady", 64'(llu_ready), 64'd1);
        nextCycle();
        idle();
        checkOutput("zeroPending", 64'(pending_mask), 64'd0);

        // Starvation of $v0 behind continuous WB writes to $t1.
        nextCycle();
        applyStimulus(1'b1, 5'd9, 32'h90, 1'b1, 5'd2, 32'hBEEF);
        expectWrite(5'd9, 32'h90);
        for (int k = 1; k <= 8; k++) begin
            nextCycle();
            applyStimulus(1'b1, 5'd9, 32'(32'h90 + k), 1'b0, 5'd0, 32'd0);
            checkOutput("starveNoStall", 64'(stall_req), 64'd0);
            expectWrite(5'd9, 32'(32'h90 + k));
        end
        nextCycle();
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        checkOutput("starveStall", 64'(stall_req), 64'd1);
        checkOutput("starvePending", 64'(pending_mask), 64'h0000_0004);
        expectWrite(5'd2, 32'hBEEF);
        nextCycle();
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        checkOutput("stallReleased", 64'(stall_req), 64'd0);
        expectWrite(5'd9, 32'h99);
        nextCycle();
        idle();
        checkOutput("starveDonePending", 64'(pending_mask), 64'd0);

        // WB to $zero leaves the port to the queued $a0.
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd7);
        nextCycle();
        applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
        checkOutput("zeroWbPending", 64'(pending_mask), 64'h0000_0010);
        expectWrite(5'd4, 32'd7);
        nextCycle();
        idle();
        checkOutput("zeroWbDone", 64'(pending_mask), 64'd0);

        nextCycle();
        nextCycle();
        checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
